bola_pool: RTL and testbench

- Pool of N_SLOTS independent projectiles for one shooter (ally or enemy) on the 640x480 playfield.
- Accepts fire requests with a cooldown and allocates the lowest free slot.
- Moves all active projectiles on a prescaled tick and retires each one at the screen edge or on a hit against a single target box.
- Sits between the shooter/player logic and the VGA drawing and scoring logic.

---
 rtl/bola_pool_if.sv | 46 ++++
 rtl/bola_pool.sv | 212 +++++++++++++++++++++
 tb/tb_bola_pool.sv | 300 ++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/bola_pool_if.sv
`default_nettype none
// ============================================================================
// Module   : bola_pool_if
// Brief    : Bus between the shooter/game logic and the projectile pool:
//            control, fire request, target box and the pool's outputs.
// Revision : 1.0 - initial release
// ============================================================================
interface bola_pool_if #(
  parameter int N_SLOTS = 4
) ();
  // control and fire request
  logic                   pausa;
  logic                   reiniciarJogo;
  logic                   disparar;
  logic [9:0]             xi;
  logic [9:0]             yi;
  // target box
  logic [9:0]             alvo_x;
  logic [9:0]             alvo_y;
  logic [9:0]             alvo_larg;
  logic [9:0]             alvo_alt;
  logic                   alvo_ativo;
  // pool outputs
  logic                   disparo_aceito;
  logic [N_SLOTS-1:0]     ativos;
  logic [10*N_SLOTS-1:0]  x_flat;
  logic [10*N_SLOTS-1:0]  y_flat;
  logic                   acerto;
  logic [N_SLOTS-1:0]     acerto_mask;
  logic [9:0]             raio;

  // game side: drives requests and target, observes the projectiles
  modport master (
    output pausa, reiniciarJogo, disparar, xi, yi,
    output alvo_x, alvo_y, alvo_larg, alvo_alt, alvo_ativo,
    input  disparo_aceito, ativos, x_flat, y_flat, acerto, acerto_mask, raio
  );

  // pool side
  modport slave (
    input  pausa, reiniciarJogo, disparar, xi, yi,
    input  alvo_x, alvo_y, alvo_larg, alvo_alt, alvo_ativo,
    output disparo_aceito, ativos, x_flat, y_flat, acerto, acerto_mask, raio
  );
endinterface
`default_nettype wire

// File: rtl/bola_pool.sv
`default_nettype none
// ============================================================================
// Module   : bola_pool
// Brief    : Pool of N_SLOTS projectiles for one shooter. Allocates the lowest
//            free slot on a fire request (with cooldown), moves all active
//            projectiles on a prescaled tick and retires them at the screen
//            edge or on a hit against a single target box.
// Revision : 1.0 - initial release
// ============================================================================
module bola_pool #(
  parameter int N_SLOTS        = 4,
  parameter int TICK_DIV       = 50000,
  parameter int STEP           = 1,
  parameter int ALIADA         = 1,
  parameter int SPAWN_OFFSET   = 35,
  parameter int COOLDOWN_TICKS = 8,
  parameter int RAIO           = 5,
  parameter int Y_MAX          = 480,
  parameter int PARK           = 1000
) (
  input wire          CLOCK_50,
  input wire          reset,
  bola_pool_if.slave  bus
);

  localparam int CNT_W = $clog2(TICK_DIV);
  localparam int CD_W  = (COOLDOWN_TICKS > 0) ? $clog2(COOLDOWN_TICKS + 1) : 1;

  localparam logic [9:0]       PARK_V   = 10'(PARK);
  localparam logic [9:0]       OFF_V    = 10'(SPAWN_OFFSET);
  localparam logic [9:0]       STEP_V   = 10'(STEP);
  localparam logic [10:0]      STEP_W   = 11'(STEP);
  localparam logic [10:0]      RAIO_W   = 11'(RAIO);
  localparam logic [10:0]      YMAX_W   = 11'(Y_MAX);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TICK_DIV - 1);
  localparam logic [CD_W-1:0]  CD_LOAD  = CD_W'(COOLDOWN_TICKS);

  // state
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic [CD_W-1:0]    cd_q, cd_d;
  logic [N_SLOTS-1:0] act_q, act_d;
  logic [9:0]         x_q [N_SLOTS];
  logic [9:0]         x_d [N_SLOTS];
  logic [9:0]         y_q [N_SLOTS];
  logic [9:0]         y_d [N_SLOTS];
  logic               acc_q, acc_d;
  logic               hit_q, hit_d;
  logic [N_SLOTS-1:0] mask_q, mask_d;

  // combinational helpers
  logic [N_SLOTS-1:0] free_vec;
  logic [N_SLOTS-1:0] alloc_oh;
  logic [N_SLOTS-1:0] hit_vec;
  logic [9:0]         spawn_y;
  logic               spawn_ok;
  logic               tick;
  logic               fire;
  logic [10:0]        box_x0, box_x1, box_y0, box_y1;
  logic [10*N_SLOTS-1:0] x_flat_w, y_flat_w;

  // Lowest inactive slot as a one-hot vector (isolate lowest set bit).
  assign free_vec = ~act_q;
  assign alloc_oh = free_vec & (~free_vec + N_SLOTS'(1));

  // Hit window widened by the projectile radius; 11-bit so nothing wraps.
  assign box_x0 = {1'b0, bus.alvo_x};
  assign box_y0 = {1'b0, bus.alvo_y};
  assign box_x1 = {1'b0, bus.alvo_x} + {1'b0, bus.alvo_larg} + RAIO_W;
  assign box_y1 = {1'b0, bus.alvo_y} + {1'b0, bus.alvo_alt} + RAIO_W;

  // Spawn position ahead of the shooter; an ally too close to the top is refused.
  always_comb begin
    spawn_y  = bus.yi + OFF_V;
    spawn_ok = 1'b1;
    if (ALIADA != 0) begin
      spawn_y  = bus.yi - OFF_V;
      spawn_ok = (bus.yi >= OFF_V);
    end
  end

  // Per-slot hit test against the registered positions of active slots.
  always_comb begin
    hit_vec = '0;
    for (int i = 0; i < N_SLOTS; i++) begin
      hit_vec[i] = act_q[i] & bus.alvo_ativo
                 & (({1'b0, x_q[i]} + RAIO_W) >= box_x0)
                 & ({1'b0, x_q[i]} <= box_x1)
                 & (({1'b0, y_q[i]} + RAIO_W) >= box_y0)
                 & ({1'b0, y_q[i]} <= box_y1);
    end
  end

  // Next-state: clear, pause hold, prescaler, cooldown, fire, move and retire.
  always_comb begin
    cnt_d  = cnt_q;
    cd_d   = cd_q;
    act_d  = act_q;
    x_d    = x_q;
    y_d    = y_q;
    acc_d  = 1'b0;
    hit_d  = 1'b0;
    mask_d = '0;
    tick   = 1'b0;
    fire   = 1'b0;

    if (bus.reiniciarJogo) begin
      cnt_d = '0;
      cd_d  = '0;
      act_d = '0;
      for (int i = 0; i < N_SLOTS; i++) begin
        x_d[i] = PARK_V;
        y_d[i] = PARK_V;
      end
    end else if (!bus.pausa) begin
      tick  = (cnt_q == CNT_LAST);
      cnt_d = tick ? '0 : cnt_q + CNT_W'(1);

      // free_vec reflects the slots inactive at the start of this cycle, so a
      // slot retiring now cannot be reused before the next cycle
      fire = bus.disparar && (cd_q == '0) && (|free_vec) && spawn_ok;

      if (fire) begin
        cd_d = CD_LOAD;
      end else if (tick && (cd_q != '0)) begin
        cd_d = cd_q - CD_W'(1);
      end

      for (int i = 0; i < N_SLOTS; i++) begin
        if (act_q[i]) begin
          // a hit takes precedence over edge retirement and movement
          if (hit_vec[i]) begin
            act_d[i] = 1'b0;
            x_d[i]   = PARK_V;
            y_d[i]   = PARK_V;
          end else if (tick) begin
            if (ALIADA != 0) begin
              if (y_q[i] < STEP_V) begin
                act_d[i] = 1'b0;
                x_d[i]   = PARK_V;
                y_d[i]   = PARK_V;
              end else begin
                y_d[i] = y_q[i] - STEP_V;
              end
            end else begin
              if (({1'b0, y_q[i]} + STEP_W) >= YMAX_W) begin
                act_d[i] = 1'b0;
                x_d[i]   = PARK_V;
                y_d[i]   = PARK_V;
              end else begin
                y_d[i] = y_q[i] + STEP_V;
              end
            end
          end
        end else if (fire && alloc_oh[i]) begin
          // freshly allocated slot does not move on this cycle's tick
          act_d[i] = 1'b1;
          x_d[i]   = bus.xi;
          y_d[i]   = spawn_y;
        end
      end

      acc_d  = fire;
      hit_d  = |hit_vec;
      mask_d = hit_vec;
    end
  end

  // State registers with asynchronous reset to the parked, idle state.
  always_ff @(posedge CLOCK_50 or posedge reset) begin
    if (reset) begin
      cnt_q  <= '0;
      cd_q   <= '0;
      act_q  <= '0;
      acc_q  <= 1'b0;
      hit_q  <= 1'b0;
      mask_q <= '0;
      for (int i = 0; i < N_SLOTS; i++) begin
        x_q[i] <= PARK_V;
        y_q[i] <= PARK_V;
      end
    end else begin
      cnt_q  <= cnt_d;
      cd_q   <= cd_d;
      act_q  <= act_d;
      acc_q  <= acc_d;
      hit_q  <= hit_d;
      mask_q <= mask_d;
      x_q    <= x_d;
      y_q    <= y_d;
    end
  end

  // Pack slot coordinates; inactive slots already hold PARK.
  always_comb begin
    x_flat_w = '0;
    y_flat_w = '0;
    for (int i = 0; i < N_SLOTS; i++) begin
      x_flat_w[10*i +: 10] = x_q[i];
      y_flat_w[10*i +: 10] = y_q[i];
    end
  end

  assign bus.disparo_aceito = acc_q;
  assign bus.ativos         = act_q;
  assign bus.x_flat         = x_flat_w;
  assign bus.y_flat         = y_flat_w;
  assign bus.acerto         = hit_q;
  assign bus.acerto_mask    = mask_q;
  assign bus.raio           = 10'(RAIO);

endmodule
`default_nettype wire

// File: tb/tb_bola_pool.sv
`default_nettype none
// ============================================================================
// Module   : tb_bola_pool
// Brief    : Scoreboard bench for bola_pool. An upward (ally) pool and a
//            downward (enemy) pool with TICK_DIV=4, COOLDOWN_TICKS=2.
// Revision : 1.0 - initial release
// ============================================================================
module tb_bola_pool;

  localparam int N    = 4;
  localparam int PARK = 1000;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   cycn  = 0;
  int   base  = 0;
  int   n_cmp = 0;
  int   n_bad = 0;

  typedef struct { int cyc; int val; int x; int y; } exp_t;
  exp_t qa_acc[$];
  exp_t qa_hit[$];
  exp_t qe_acc[$];

  always #5 clk = ~clk;
  always @(posedge clk) cycn <= cycn + 1;

  bola_pool_if #(.N_SLOTS(N)) ifa ();
  bola_pool_if #(.N_SLOTS(N)) ife ();

  bola_pool #(.N_SLOTS(N), .TICK_DIV(4), .STEP(1), .ALIADA(1), .SPAWN_OFFSET(35),
              .COOLDOWN_TICKS(2), .RAIO(5), .Y_MAX(480), .PARK(PARK))
    dut_a (.CLOCK_50(clk), .reset(rst), .bus(ifa));

  bola_pool #(.N_SLOTS(N), .TICK_DIV(4), .STEP(1), .ALIADA(0), .SPAWN_OFFSET(35),
              .COOLDOWN_TICKS(2), .RAIO(5), .Y_MAX(480), .PARK(PARK))
    dut_e (.CLOCK_50(clk), .reset(rst), .bus(ife));

  task automatic chk(input string name, input int act, input int exp);
    n_cmp++;
    if (act != exp) begin
      n_bad++;
      $display("FAIL %s: got %0d, expected %0d (cycle %0d)", name, act, exp, cycn - base);
    end
  endtask

  function automatic int xa(input int s); return int'(ifa.x_flat[10*s +: 10]); endfunction
  function automatic int ya(input int s); return int'(ifa.y_flat[10*s +: 10]); endfunction
  function automatic int ye(input int s); return int'(ife.y_flat[10*s +: 10]); endfunction

  task automatic step(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  // one-cycle synchronous clear; afterwards the prescaler is at 0 (cycle 0)
  task automatic restart();
    ifa.reiniciarJogo = 1'b1;
    ife.reiniciarJogo = 1'b1;
    step(1);
    ifa.reiniciarJogo = 1'b0;
    ife.reiniciarJogo = 1'b0;
    base = cycn;
  endtask

  task automatic push_acc_a(input int dc, input int slot, input int x, input int y);
    exp_t e;
    e.cyc = base + dc; e.val = slot; e.x = x; e.y = y;
    qa_acc.push_back(e);
  endtask

  task automatic push_hit_a(input int dc, input int mask);
    exp_t e;
    e.cyc = base + dc; e.val = mask; e.x = 0; e.y = 0;
    qa_hit.push_back(e);
  endtask

  task automatic push_acc_e(input int dc, input int slot, input int x, input int y);
    exp_t e;
    e.cyc = base + dc; e.val = slot; e.x = x; e.y = y;
    qe_acc.push_back(e);
  endtask

  // two projectiles placed at (100,312) and (86,305) in cycle 9, target idle
  task automatic setup_two();
    restart();
    ifa.alvo_x = 10'd90; ifa.alvo_y = 10'd300; ifa.alvo_larg = 10'd20; ifa.alvo_alt = 10'd10;
    ifa.alvo_ativo = 1'b0;
    ifa.xi = 10'd100; ifa.yi = 10'd349; ifa.disparar = 1'b1;
    push_acc_a(1, 0, 100, 314);
    step(1);
    ifa.disparar = 1'b0;
    step(7);
    ifa.xi = 10'd86; ifa.yi = 10'd340; ifa.disparar = 1'b1;
    push_acc_a(9, 1, 86, 305);
    step(1);
    ifa.disparar = 1'b0;
    chk("hit_setup_y0", ya(0), 312);
    chk("hit_setup_y1", ya(1), 305);
  endtask

  // monitor for the ally pool: every pulse is matched against the scoreboard
  always @(negedge clk) begin : mon_a
    exp_t e;
    if (rst == 1'b0) begin
      if (ifa.disparo_aceito) begin
        if (qa_acc.size() == 0) chk("a_unexpected_accept", 1, 0);
        else begin
          e = qa_acc.pop_front();
          chk("a_accept_cycle", cycn, e.cyc);
          chk("a_accept_active", int'(ifa.ativos[e.val]), 1);
          chk("a_accept_x", xa(e.val), e.x);
          chk("a_accept_y", ya(e.val), e.y);
        end
      end
      if (ifa.acerto) begin
        if (qa_hit.size() == 0) chk("a_unexpected_hit", 1, 0);
        else begin
          e = qa_hit.pop_front();
          chk("a_hit_cycle", cycn, e.cyc);
          chk("a_hit_mask", int'(ifa.acerto_mask), e.val);
          chk("a_hit_retired", int'(ifa.ativos) & e.val, 0);
        end
      end
    end
  end

  // monitor for the enemy pool
  always @(negedge clk) begin : mon_e
    exp_t e;
    if (rst == 1'b0) begin
      if (ife.disparo_aceito) begin
        if (qe_acc.size() == 0) chk("e_unexpected_accept", 1, 0);
        else begin
          e = qe_acc.pop_front();
          chk("e_accept_cycle", cycn, e.cyc);
          chk("e_accept_y", ye(e.val), e.y);
        end
      end
      if (ife.acerto) chk("e_unexpected_hit", 1, 0);
    end
  end

  initial begin
    #100000;
    $display("FAIL watchdog: time limit reached");
    $fatal(1);
  end

  initial begin : stim
    exp_t d;
    ifa.pausa = 1'b0; ifa.reiniciarJogo = 1'b0; ifa.disparar = 1'b0;
    ifa.xi = '0; ifa.yi = '0; ifa.alvo_x = '0; ifa.alvo_y = '0;
    ifa.alvo_larg = '0; ifa.alvo_alt = '0; ifa.alvo_ativo = 1'b0;
    ife.pausa = 1'b0; ife.reiniciarJogo = 1'b0; ife.disparar = 1'b0;
    ife.xi = '0; ife.yi = '0; ife.alvo_x = '0; ife.alvo_y = '0;
    ife.alvo_larg = '0; ife.alvo_alt = '0; ife.alvo_ativo = 1'b0;

    // power-on reset state
    step(2);
    chk("reset_ativos", int'(ifa.ativos), 0);
    chk("reset_accept", int'(ifa.disparo_aceito), 0);
    chk("reset_acerto", int'(ifa.acerto), 0);
    chk("reset_mask", int'(ifa.acerto_mask), 0);
    chk("raio", int'(ifa.raio), 5);
    for (int s = 0; s < N; s++) begin
      chk("reset_x", xa(s), PARK);
      chk("reset_y", ya(s), PARK);
    end
    rst = 1'b0;

    // held fire: accepts every 8 cycles into slots 0..3, fifth refused
    restart();
    ifa.xi = 10'd100; ifa.yi = 10'd400; ifa.disparar = 1'b1;
    for (int k = 0; k < 4; k++) push_acc_a(1 + 8*k, k, 100, 365);
    step(40);
    ifa.disparar = 1'b0;
    chk("hold_all_active", int'(ifa.ativos), 15);
    chk("hold_y0", ya(0), 355);
    chk("hold_y3", ya(3), 361);

    // reset mid-flight with three slots active
    restart();
    ifa.disparar = 1'b1;
    for (int k = 0; k < 3; k++) push_acc_a(1 + 8*k, k, 100, 365);
    step(18);
    ifa.disparar = 1'b0;
    step(2);
    rst = 1'b1;
    #1;
    chk("midreset_ativos", int'(ifa.ativos), 0);
    chk("midreset_accept", int'(ifa.disparo_aceito), 0);
    chk("midreset_acerto", int'(ifa.acerto), 0);
    for (int s = 0; s < N; s++) begin
      chk("midreset_x", xa(s), PARK);
      chk("midreset_y", ya(s), PARK);
    end
    step(2);
    rst = 1'b0;
    base = cycn;

    // single shot straight after reset: prescaler starts from 0
    ifa.xi = 10'd100; ifa.yi = 10'd400; ifa.disparar = 1'b1;
    push_acc_a(1, 0, 100, 365);
    step(1);
    ifa.disparar = 1'b0;
    step(2);
    chk("single_y_before_tick", ya(0), 365);
    step(1);
    chk("single_y_after_tick", ya(0), 364);

    // ally spawn too close to the top is refused
    restart();
    ifa.xi = 10'd50; ifa.yi = 10'd34; ifa.disparar = 1'b1;
    step(1);
    ifa.disparar = 1'b0;
    chk("reject_low_yi", int'(ifa.ativos), 0);

    // ally top edge: y=1 -> 0 -> retired
    restart();
    ifa.yi = 10'd36; ifa.disparar = 1'b1;
    push_acc_a(1, 0, 50, 1);
    step(1);
    ifa.disparar = 1'b0;
    step(2);
    chk("top_y1", ya(0), 1);
    step(1);
    chk("top_y0", ya(0), 0);
    step(3);
    chk("top_still_active", int'(ifa.ativos), 1);
    step(1);
    chk("top_retired", int'(ifa.ativos), 0);
    chk("top_park_y", ya(0), PARK);

    // enemy bottom edge: y=479 retires on the next tick
    restart();
    ife.xi = 10'd200; ife.yi = 10'd444; ife.disparar = 1'b1;
    push_acc_e(1, 0, 200, 479);
    step(1);
    ife.disparar = 1'b0;
    step(2);
    chk("bottom_active", int'(ife.ativos), 1);
    chk("bottom_y479", ye(0), 479);
    step(1);
    chk("bottom_retired", int'(ife.ativos), 0);
    chk("bottom_park_y", ye(0), PARK);

    // double hit against box (90,300,20,10)
    setup_two();
    ifa.alvo_ativo = 1'b1;
    push_hit_a(10, 3);
    step(1);
    ifa.alvo_ativo = 1'b0;
    chk("double_hit_cleared", int'(ifa.ativos), 0);

    // same layout with the target disabled, then x-edge boundary hits
    setup_two();
    step(1);
    chk("no_hit_disabled", int'(ifa.ativos), 3);
    ifa.alvo_x = 10'd92; ifa.alvo_ativo = 1'b1;
    push_hit_a(11, 1);
    step(1);
    ifa.alvo_x = 10'd91;
    push_hit_a(12, 2);
    step(1);
    ifa.alvo_ativo = 1'b0;
    chk("edge_hits_cleared", int'(ifa.ativos), 0);

    // pause for 21 cycles with fire held: everything frozen
    restart();
    ifa.xi = 10'd100; ifa.yi = 10'd400; ifa.disparar = 1'b1;
    push_acc_a(1, 0, 100, 365);
    step(1);
    ifa.disparar = 1'b0;
    step(7);
    ifa.pausa = 1'b1; ifa.disparar = 1'b1;
    step(20);
    chk("pause_y0", ya(0), 363);
    chk("pause_ativos", int'(ifa.ativos), 1);
    step(1);
    ifa.pausa = 1'b0;
    push_acc_a(30, 1, 100, 365);
    step(1);
    ifa.disparar = 1'b0;
    step(2);
    chk("resume_y0_held_count", ya(0), 363);
    step(1);
    chk("resume_y0_tick", ya(0), 362);

    step(3);
    while (qa_acc.size() > 0) begin d = qa_acc.pop_front(); chk("a_missing_accept_cycle", 0, d.cyc); end
    while (qa_hit.size() > 0) begin d = qa_hit.pop_front(); chk("a_missing_hit_cycle", 0, d.cyc); end
    while (qe_acc.size() > 0) begin d = qe_acc.pop_front(); chk("e_missing_accept_cycle", 0, d.cyc); end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
`default_nettype wire
